// File: rtl/example_mac_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : example_mac_pipe_if
// Brief    : Operand/tag input bundle and product/accumulator result bundle
// Revision : 1.0 - initial release
// ============================================================================
interface example_mac_pipe_if #(
  parameter int A_WIDTH   = 9,
  parameter int B_WIDTH   = 14,
  parameter int P_WIDTH   = 21,
  parameter int ACC_WIDTH = 32
);
  logic                 ce;
  logic                 in_valid;
  logic [A_WIDTH-1:0]   a;
  logic [B_WIDTH-1:0]   b;
  logic                 acc_first;
  logic                 acc_last;
  logic [P_WIDTH-1:0]   p_out;
  logic                 p_valid;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_valid;
  logic                 acc_ovf;

  modport master (
    output ce, in_valid, a, b, acc_first, acc_last,
    input  p_out, p_valid, acc_out, acc_valid, acc_ovf
  );

  modport slave (
    input  ce, in_valid, a, b, acc_first, acc_last,
    output p_out, p_valid, acc_out, acc_valid, acc_ovf
  );
endinterface
`default_nettype wire

// File: rtl/example_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : example_mac_pipe
// Brief    : Pipelined multiplier with tagged, optionally saturating accumulate
// Revision : 1.0 - initial release
// ============================================================================
module example_mac_pipe #(
  parameter int A_WIDTH   = 9,
  parameter int B_WIDTH   = 14,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int P_WIDTH   = 21,
  parameter int NUM_STAGE = 3,
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  example_mac_pipe_if.slave  bus
);

  localparam int c_fw   = A_WIDTH + B_WIDTH + 1;
  localparam int c_last = NUM_STAGE - 1;
  localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [c_fw-1:0]    w_a_ext;
  logic signed [c_fw-1:0]    w_b_ext;
  logic signed [c_fw-1:0]    w_full;
  logic signed [c_fw-1:0]    r_full [NUM_STAGE];
  logic [NUM_STAGE-1:0]      r_vld;
  logic [NUM_STAGE-1:0]      r_first;
  logic [NUM_STAGE-1:0]      r_last;
  logic [ACC_WIDTH:0]        w_addend;
  logic [ACC_WIDTH:0]        w_base;
  logic [ACC_WIDTH:0]        w_sum;
  logic                      w_ovf;
  logic [ACC_WIDTH-1:0]      w_acc_next;
  logic [ACC_WIDTH-1:0]      r_acc;
  logic                      r_acc_ovf;
  logic                      r_acc_valid;

  generate
    if (A_SIGNED != 0) begin : g_a_sext
      assign w_a_ext = {{(c_fw-A_WIDTH){bus.a[A_WIDTH-1]}}, bus.a};
    end else begin : g_a_zext
      assign w_a_ext = {{(c_fw-A_WIDTH){1'b0}}, bus.a};
    end
    if (B_SIGNED != 0) begin : g_b_sext
      assign w_b_ext = {{(c_fw-B_WIDTH){bus.b[B_WIDTH-1]}}, bus.b};
    end else begin : g_b_zext
      assign w_b_ext = {{(c_fw-B_WIDTH){1'b0}}, bus.b};
    end
  endgenerate

  // FW bits always hold the exact product of the extended operands
  assign w_full = w_a_ext * w_b_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_full[i] <= '0;
      end
      r_vld   <= '0;
      r_first <= '0;
      r_last  <= '0;
    end else if (bus.ce) begin
      r_full[0]  <= w_full;
      r_vld[0]   <= bus.in_valid;
      r_first[0] <= bus.acc_first;
      r_last[0]  <= bus.acc_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_full[i]  <= r_full[i-1];
        r_vld[i]   <= r_vld[i-1];
        r_first[i] <= r_first[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  // One guard bit above the accumulator exposes signed overflow
  assign w_addend = {{(ACC_WIDTH+1-c_fw){r_full[c_last][c_fw-1]}}, r_full[c_last]};
  assign w_base   = r_first[c_last] ? '0 : {r_acc[ACC_WIDTH-1], r_acc};
  assign w_sum    = w_base + w_addend;
  assign w_ovf    = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_ovf && (SATURATE != 0)) begin
      w_acc_next = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_acc_ovf   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else if (bus.ce) begin
      if (r_vld[c_last]) begin
        r_acc       <= w_acc_next;
        r_acc_ovf   <= (r_first[c_last] ? 1'b0 : r_acc_ovf) | w_ovf;
        r_acc_valid <= r_last[c_last];
      end else begin
        r_acc_valid <= 1'b0;
      end
    end
  end

  assign bus.p_out     = r_full[c_last][P_WIDTH-1:0];
  assign bus.p_valid   = r_vld[c_last];
  assign bus.acc_out   = r_acc;
  assign bus.acc_valid = r_acc_valid;
  assign bus.acc_ovf   = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_example_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_example_mac_pipe
// Brief    : Three configurations of example_mac_pipe against a reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_example_mac_pipe;

  typedef struct {
    bit          v;
    bit          f;
    bit          l;
    logic [8:0]  a;
    logic [13:0] b;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        acc_first = 1'b0;
  logic        acc_last = 1'b0;
  logic [8:0]  a = '0;
  logic [13:0] b = '0;

  int total = 0;
  int bad   = 0;

  rec_t   recs[$];
  int     n = 0;
  longint m_acc [3];
  bit     m_ovf [3];
  bit     m_av  [3];

  logic [20:0] pout [3];
  logic        pv   [3];
  logic        av   [3];
  logic        ovf  [3];
  logic [31:0] aout [3];

  always #5 clk = ~clk;

  example_mac_pipe_if #(.A_WIDTH(9), .B_WIDTH(14), .P_WIDTH(21), .ACC_WIDTH(32)) if0 ();
  example_mac_pipe_if #(.A_WIDTH(9), .B_WIDTH(14), .P_WIDTH(21), .ACC_WIDTH(24)) if1 ();
  example_mac_pipe_if #(.A_WIDTH(9), .B_WIDTH(14), .P_WIDTH(21), .ACC_WIDTH(24)) if2 ();

  assign if0.ce = ce;  assign if0.in_valid = in_valid;  assign if0.a = a;  assign if0.b = b;
  assign if0.acc_first = acc_first;  assign if0.acc_last = acc_last;
  assign if1.ce = ce;  assign if1.in_valid = in_valid;  assign if1.a = a;  assign if1.b = b;
  assign if1.acc_first = acc_first;  assign if1.acc_last = acc_last;
  assign if2.ce = ce;  assign if2.in_valid = in_valid;  assign if2.a = a;  assign if2.b = b;
  assign if2.acc_first = acc_first;  assign if2.acc_last = acc_last;

  example_mac_pipe #(.A_WIDTH(9), .B_WIDTH(14), .A_SIGNED(0), .B_SIGNED(1), .P_WIDTH(21),
                     .NUM_STAGE(3), .ACC_WIDTH(32), .SATURATE(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  example_mac_pipe #(.A_WIDTH(9), .B_WIDTH(14), .A_SIGNED(1), .B_SIGNED(0), .P_WIDTH(21),
                     .NUM_STAGE(2), .ACC_WIDTH(24), .SATURATE(1))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  example_mac_pipe #(.A_WIDTH(9), .B_WIDTH(14), .A_SIGNED(0), .B_SIGNED(1), .P_WIDTH(21),
                     .NUM_STAGE(3), .ACC_WIDTH(24), .SATURATE(0))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  assign pout[0] = if0.p_out;    assign pout[1] = if1.p_out;    assign pout[2] = if2.p_out;
  assign pv[0]   = if0.p_valid;  assign pv[1]   = if1.p_valid;  assign pv[2]   = if2.p_valid;
  assign av[0]   = if0.acc_valid; assign av[1]  = if1.acc_valid; assign av[2]  = if2.acc_valid;
  assign ovf[0]  = if0.acc_ovf;  assign ovf[1]  = if1.acc_ovf;  assign ovf[2]  = if2.acc_ovf;
  assign aout[0] = if0.acc_out;
  assign aout[1] = {8'd0, if1.acc_out};
  assign aout[2] = {8'd0, if2.acc_out};

  function automatic int ns_of(int d);
    return (d == 1) ? 2 : 3;
  endfunction

  function automatic int accw_of(int d);
    return (d == 0) ? 32 : 24;
  endfunction

  // Exact mathematical product under each configuration's signedness
  function automatic longint full_of(int d, logic [8:0] av_in, logic [13:0] bv_in);
    longint ea;
    longint eb;
    ea = longint'(av_in);
    eb = longint'(bv_in);
    if (d == 1 && av_in[8]) ea = ea - 512;
    if (d != 1 && bv_in[13]) eb = eb - 16384;
    return ea * eb;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    recs.delete();
    n = 0;
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
      m_av[d]  = 1'b0;
    end
  endtask

  // One enabled clock edge: record the sampled input, retire one product per config
  task automatic model_edge();
    rec_t   r;
    int     j;
    int     w;
    longint s;
    longint hi;
    longint lo;
    bit     o;
    r.v = in_valid;  r.f = acc_first;  r.l = acc_last;  r.a = a;  r.b = b;
    recs.push_back(r);
    n++;
    for (int d = 0; d < 3; d++) begin
      j = n - ns_of(d) - 1;
      m_av[d] = 1'b0;
      if (j >= 0 && recs[j].v) begin
        w  = accw_of(d);
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        s  = (recs[j].f ? 0 : m_acc[d]) + full_of(d, recs[j].a, recs[j].b);
        o  = (s > hi) || (s < lo);
        if (o && d == 1) begin
          s = (s > hi) ? hi : lo;
        end else if (o) begin
          s = s & ((longint'(1) <<< w) - 1);
          if (s > hi) s = s - (longint'(1) <<< w);
        end
        m_acc[d] = s;
        m_ovf[d] = (recs[j].f ? 1'b0 : m_ovf[d]) | o;
        m_av[d]  = recs[j].l;
      end
    end
  endtask

  task automatic check_all();
    int  k;
    bit  ev;
    longint msk;
    for (int d = 0; d < 3; d++) begin
      k  = n - ns_of(d);
      ev = (k >= 0) ? recs[k].v : 1'b0;
      check($sformatf("d%0d_p_valid", d), 64'(pv[d]), 64'(ev));
      if (ev) begin
        check($sformatf("d%0d_p_out", d), 64'(pout[d]),
              64'(full_of(d, recs[k].a, recs[k].b) & 64'h1FFFFF));
      end
      msk = (longint'(1) <<< accw_of(d)) - 1;
      check($sformatf("d%0d_acc_valid", d), 64'(av[d]), 64'(m_av[d]));
      check($sformatf("d%0d_acc_ovf", d), 64'(ovf[d]), 64'(m_ovf[d]));
      check($sformatf("d%0d_acc_out", d), 64'(aout[d]), 64'(m_acc[d] & msk));
    end
  endtask

  task automatic check_zero(string when);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_d%0d_p_out", when, d), 64'(pout[d]), 64'd0);
      check($sformatf("%s_d%0d_p_valid", when, d), 64'(pv[d]), 64'd0);
      check($sformatf("%s_d%0d_acc_out", when, d), 64'(aout[d]), 64'd0);
      check($sformatf("%s_d%0d_acc_valid", when, d), 64'(av[d]), 64'd0);
      check($sformatf("%s_d%0d_acc_ovf", when, d), 64'(ovf[d]), 64'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset && ce) model_edge();
    #1;
    check_all();
  endtask

  task automatic put(bit c, bit v, logic [8:0] av_in, logic [13:0] bv_in, bit f, bit l);
    ce = c;  in_valid = v;  a = av_in;  b = bv_in;  acc_first = f;  acc_last = l;
    cycle();
  endtask

  task automatic idle(int cnt);
    for (int i = 0; i < cnt; i++) put(1'b1, 1'b0, 9'd0, 14'd0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("rst");

    // single product, single-term sum
    put(1, 1, 9'd3, 14'h3FFB, 1, 1);
    idle(5);

    // truncation and signedness of the largest-magnitude operands
    put(1, 1, 9'h1FF, 14'h2000, 1, 0);
    put(1, 1, 9'h1FF, 14'h2000, 0, 0);
    put(1, 1, 9'h1FF, 14'h2000, 0, 1);
    idle(5);

    // three-term accumulation, back to back
    put(1, 1, 9'd3, 14'h3FFB, 1, 0);
    put(1, 1, 9'd4, 14'd7, 0, 0);
    put(1, 1, 9'd10, 14'd10, 0, 1);
    idle(5);

    // drives the saturating configuration into negative clamp
    put(1, 1, 9'h100, 14'h3FFF, 1, 0);
    put(1, 1, 9'h100, 14'h3FFF, 0, 0);
    put(1, 1, 9'h100, 14'h3FFF, 0, 1);
    idle(5);

    // five-input stream with a two-cycle stall in the middle
    put(1, 1, 9'd7, 14'd100, 1, 0);
    put(1, 1, 9'd9, 14'h3F00, 0, 0);
    put(0, 1, 9'd9, 14'h3F00, 0, 0);
    put(0, 1, 9'd9, 14'h3F00, 0, 0);
    put(1, 1, 9'd300, 14'd5000, 0, 0);
    put(1, 1, 9'd1, 14'd1, 0, 0);
    put(1, 1, 9'd2, 14'd2, 0, 1);
    put(0, 0, 9'd0, 14'd0, 0, 0);
    put(0, 0, 9'd0, 14'd0, 0, 0);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      put(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
          9'($urandom), 14'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset between edges with products in flight
    idle(6);
    put(1, 1, 9'd5, 14'd6, 1, 0);
    put(1, 1, 9'd8, 14'h3FF0, 0, 0);
    put(1, 1, 9'd11, 14'd13, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    #2;
    reset = 1'b0;
    idle(2);
    put(1, 1, 9'd3, 14'h3FFB, 1, 1);
    idle(6);

    for (int i = 0; i < 200; i++) begin
      put(($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0),
          9'($urandom), 14'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
